// File: rtl/rs_encoder_param.sv
// Systematic Reed-Solomon encoder over GF(256): passes message symbols through
// a registered output stage, then emits NPAR parity symbols from an LFSR divider.
module rs_encoder_param #(
   parameter int unsigned       NPAR      = 8,
   parameter int unsigned       MAX_K     = 247,
   parameter logic [8*NPAR-1:0] GEN       = 64'he3_2c_b2_47_ac_08_e0_25,
   parameter logic [8:0]        PRIM_POLY = 9'h11d
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_val,
   input  logic       din_sop,
   input  logic       din_eop,
   output logic       din_rdy,
   output logic [7:0] dout,
   output logic       dout_val,
   output logic       dout_sop,
   output logic       dout_eop,
   input  logic       dout_rdy,
   output logic       busy,
   output logic       err_len,
   output logic       err_proto
);

   typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

   state_t     state, state_nxt;
   logic [7:0] rem     [NPAR];
   logic [7:0] rem_nxt [NPAR];
   logic [8:0] cnt, cnt_nxt;
   logic [5:0] pcnt, pcnt_nxt;
   logic [7:0] fb;
   logic       out_free, accept, par_last;
   logic       load_msg, load_par, div_sop;
   logic       err_len_nxt, err_proto_nxt;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ PRIM_POLY[7:0]) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   assign out_free = !dout_val || dout_rdy;
   assign din_rdy  = !rst && (state != PAR) && out_free;
   assign accept   = din_val && din_rdy;
   assign par_last = (pcnt == 6'(NPAR - 1));
   assign busy     = (state != IDLE) || dout_val;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      pcnt_nxt      = pcnt;
      load_msg      = 1'b0;
      load_par      = 1'b0;
      div_sop       = 1'b0;
      err_len_nxt   = 1'b0;
      err_proto_nxt = 1'b0;
      case (state)
         IDLE, MSG: begin
            if (accept) begin
               // In IDLE only a sop beat starts a codeword; in MSG a sop beat restarts one.
               if (din_sop || state == MSG) begin
                  load_msg      = 1'b1;
                  div_sop       = din_sop;
                  err_proto_nxt = din_sop && (state == MSG);
                  cnt_nxt       = din_sop ? 9'd1 : cnt + 9'd1;
                  if (din_eop) begin
                     state_nxt = PAR;
                  end else if (cnt_nxt == 9'(MAX_K)) begin
                     state_nxt   = PAR;
                     err_len_nxt = 1'b1;
                  end else begin
                     state_nxt = MSG;
                  end
               end else begin
                  err_proto_nxt = 1'b1;
               end
            end
         end
         PAR: begin
            if (out_free) begin
               load_par = 1'b1;
               if (par_last) begin
                  state_nxt = IDLE;
                  pcnt_nxt  = '0;
               end else begin
                  pcnt_nxt = pcnt + 6'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      fb = din ^ (div_sop ? 8'h00 : rem[NPAR-1]);
      for (int unsigned i = 0; i < NPAR; i++) rem_nxt[i] = rem[i];
      if (load_msg) begin
         rem_nxt[0] = gf_mul(fb, GEN[7:0]);
         for (int unsigned i = 1; i < NPAR; i++)
            rem_nxt[i] = (div_sop ? 8'h00 : rem[i-1]) ^ gf_mul(fb, GEN[8*i +: 8]);
      end else if (load_par) begin
         rem_nxt[0] = '0;
         for (int unsigned i = 1; i < NPAR; i++) rem_nxt[i] = rem[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NPAR; i++) rem[i] <= '0;
         cnt       <= '0;
         pcnt      <= '0;
         dout      <= '0;
         dout_val  <= 1'b0;
         dout_sop  <= 1'b0;
         dout_eop  <= 1'b0;
         err_len   <= 1'b0;
         err_proto <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NPAR; i++) rem[i] <= rem_nxt[i];
         cnt       <= cnt_nxt;
         pcnt      <= pcnt_nxt;
         err_len   <= err_len_nxt;
         err_proto <= err_proto_nxt;
         if (load_msg) begin
            dout     <= din;
            dout_val <= 1'b1;
            dout_sop <= din_sop;
            dout_eop <= 1'b0;
         end else if (load_par) begin
            dout     <= rem[NPAR-1];
            dout_val <= 1'b1;
            dout_sop <= 1'b0;
            dout_eop <= par_last;
         end else if (out_free) begin
            dout_val <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rs_encoder_param.sv
// Directed bench for rs_encoder_param: constant vectors for the single-symbol
// codeword, and a long-division reference encoder for the longer messages.
module tb_rs_encoder_param;

   localparam logic [63:0] GEN_TB = 64'he3_2c_b2_47_ac_08_e0_25;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din_val, din_sop, din_eop, din_rdy;
   logic [7:0] dout;
   logic       dout_val, dout_sop, dout_eop, dout_rdy;
   logic       busy, err_len, err_proto;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;
   int unsigned acc_cyc = 0;
   int unsigned n_len = 0;
   int unsigned n_proto = 0;
   logic        last_acc = 1'b0;

   logic [9:0]  outq  [$];
   logic [9:0]  exp_q [$];
   int unsigned cycq  [$];
   logic [7:0]  msg   [$];

   rs_encoder_param #(.NPAR(8), .MAX_K(247)) dut (
      .clk(clk), .rst(rst),
      .din(din), .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop), .din_rdy(din_rdy),
      .dout(dout), .dout_val(dout_val), .dout_sop(dout_sop), .dout_eop(dout_eop),
      .dout_rdy(dout_rdy), .busy(busy), .err_len(err_len), .err_proto(err_proto)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs are sampled and transfers logged on the falling edge; returns #1 after the rising edge.
   task automatic tick();
      @(negedge clk);
      last_acc = din_val && din_rdy;
      if (last_acc) acc_cyc = cyc;
      if (dout_val && dout_rdy) begin
         outq.push_back({dout_sop, dout_eop, dout});
         cycq.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (err_len === 1'b1)   n_len++;
      if (err_proto === 1'b1) n_proto++;
   endtask

   task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
      int unsigned n;
      logic got;
      n = 0;
      got = 1'b0;
      din = d; din_val = 1'b1; din_sop = s; din_eop = e;
      while (!got && n < 300) begin
         tick();
         got = last_acc;
         n++;
      end
      din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
      if (!got) check("beat_accept_timeout", {31'd0, got}, 32'd1);
   endtask

   task automatic send_msg(input logic with_eop);
      for (int j = 0; j < msg.size(); j++)
         send_beat(msg[j], j == 0, with_eop && (j == msg.size() - 1));
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while (busy !== 1'b0 && n < 600) begin
         tick();
         n++;
      end
      if (busy !== 1'b0) check("drain_timeout", {31'd0, busy}, 32'd0);
   endtask

   function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int k = 7; k >= 0; k--) begin
         p = p[7] ? ({p[6:0], 1'b0} ^ 8'h1d) : {p[6:0], 1'b0};
         if (b[k]) p = p ^ a;
      end
      return p;
   endfunction

   task automatic add_raw();
      for (int j = 0; j < msg.size(); j++) exp_q.push_back({j == 0, 1'b0, msg[j]});
   endtask

   // Reference: long division of msg(x)*x^8 by the monic generator.
   task automatic add_codeword();
      logic [7:0] r [0:263];
      logic [7:0] c;
      int L;
      L = msg.size();
      for (int i = 0; i < 264; i++) r[i] = 8'h00;
      for (int j = 0; j < L; j++) r[j] = msg[j];
      for (int j = 0; j < L; j++) begin
         c = r[j];
         for (int i = 1; i <= 8; i++) r[j+i] = r[j+i] ^ tb_mul(c, GEN_TB[8*(8-i) +: 8]);
      end
      add_raw();
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, i == 7, r[L+i]});
   endtask

   task automatic compare_q(input string tag);
      check({tag, "_count"}, outq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < outq.size(); i++)
         check($sformatf("%s_sym%0d", tag, i), {22'd0, outq[i]}, {22'd0, exp_q[i]});
   endtask

   initial begin
      int unsigned n, p0, l0;
      logic got;
      rst = 1'b1; din = 8'h00; din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0; dout_rdy = 1'b1;

      // reset state
      tick(); tick();
      check("rst_dout_val", {31'd0, dout_val}, 32'd0);
      check("rst_dout", {24'd0, dout}, 32'd0);
      check("rst_dout_sop", {31'd0, dout_sop}, 32'd0);
      check("rst_dout_eop", {31'd0, dout_eop}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_din_rdy", {31'd0, din_rdy}, 32'd0);
      check("rst_errs", {30'd0, err_len, err_proto}, 32'd0);
      rst = 1'b0;
      #1;
      check("din_rdy_after_rst", {31'd0, din_rdy}, 32'd1);

      // single 0x01 codeword, constant expected sequence
      exp_q = {10'h201, 10'h0e3, 10'h02c, 10'h0b2, 10'h047, 10'h0ac, 10'h008, 10'h0e0, 10'h125};
      outq = {}; cycq = {};
      msg = {8'h01};
      send_msg(1'b1);
      drain();
      compare_q("single");
      if (cycq.size() == 9) begin
         check("single_latency", cycq[0] - acc_cyc, 32'd1);
         check("single_contig", cycq[8] - cycq[0], 32'd8);
      end

      // same codeword with back-pressure while 0x2c is presented
      outq = {}; cycq = {};
      send_msg(1'b1);
      n = 0;
      while (!(dout_val === 1'b1 && dout === 8'h2c) && n < 20) begin
         tick();
         n++;
      end
      check("hold_reach_2c", {24'd0, dout}, 32'h2c);
      dout_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("hold_dout_%0d", k), {21'd0, dout_val, dout_sop, dout_eop, dout}, {21'd0, 3'b100, 8'h2c});
         check($sformatf("hold_busy_%0d", k), {31'd0, busy}, 32'd1);
      end
      dout_rdy = 1'b1;
      drain();
      compare_q("hold");

      // 247 zero symbols: full-length codeword, eop wins over length limit
      outq = {}; cycq = {}; exp_q = {};
      msg = {};
      for (int j = 0; j < 247; j++) msg.push_back(8'h00);
      add_codeword();
      l0 = n_len;
      send_msg(1'b1);
      drain();
      compare_q("zeros");
      if (cycq.size() == 255) check("zeros_contig", cycq[254] - cycq[0], 32'd254);
      check("zeros_no_err_len", n_len - l0, 32'd0);

      // sop at beat 5 aborts the first codeword
      outq = {}; exp_q = {};
      msg = {8'h11, 8'h22, 8'h33, 8'h44};
      add_raw();
      msg = {8'h5a, 8'ha5, 8'h01, 8'h02, 8'h03, 8'hfe};
      add_codeword();
      p0 = n_proto;
      send_beat(8'h11, 1'b1, 1'b0);
      send_beat(8'h22, 1'b0, 1'b0);
      send_beat(8'h33, 1'b0, 1'b0);
      send_beat(8'h44, 1'b0, 1'b0);
      send_beat(8'h5a, 1'b1, 1'b0);
      check("abort_err_proto", {31'd0, err_proto}, 32'd1);
      send_msg_tail();
      drain();
      compare_q("abort");
      check("abort_proto_count", n_proto - p0, 32'd1);

      // 248 beats without eop: length limit at beat 247
      outq = {}; exp_q = {};
      msg = {};
      for (int j = 0; j < 247; j++) msg.push_back(8'(j + 1));
      add_codeword();
      p0 = n_proto; l0 = n_len;
      send_msg(1'b0);
      check("len_err_pulse", {31'd0, err_len}, 32'd1);
      din = 8'h77; din_val = 1'b1; din_sop = 1'b0; din_eop = 1'b0;
      check("len_rdy_in_par", {31'd0, din_rdy}, 32'd0);
      n = 0; got = 1'b0;
      while (!got && n < 50) begin
         tick();
         got = last_acc;
         n++;
      end
      check("len_beat248_taken", {31'd0, got}, 32'd1);
      check("len_beat248_proto", {31'd0, err_proto}, 32'd1);
      din_val = 1'b0;
      drain();
      compare_q("len");
      check("len_err_count", n_len - l0, 32'd1);
      check("len_proto_count", n_proto - p0, 32'd1);

      // reset while the third parity symbol is presented
      outq = {}; exp_q = {};
      msg = {8'hde, 8'had, 8'hbe};
      add_codeword();
      send_msg(1'b1);
      n = 0;
      while (!(outq.size() == 5 && dout_val === 1'b1) && n < 50) begin
         tick();
         n++;
      end
      check("rstpar_third", {24'd0, dout}, {24'd0, exp_q[5][7:0]});
      rst = 1'b1;
      tick();
      check("rstpar_val", {31'd0, dout_val}, 32'd0);
      check("rstpar_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      outq = {};
      for (int k = 0; k < 4; k++) tick();
      check("rstpar_no_tail", outq.size(), 32'd0);
      exp_q = {};
      msg = {8'h12, 8'h34, 8'h56, 8'h78};
      add_codeword();
      send_msg(1'b1);
      drain();
      compare_q("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Remaining beats of the second codeword in the abort scenario.
   task automatic send_msg_tail();
      send_beat(8'ha5, 1'b0, 1'b0);
      send_beat(8'h01, 1'b0, 1'b0);
      send_beat(8'h02, 1'b0, 1'b0);
      send_beat(8'h03, 1'b0, 1'b0);
      send_beat(8'hfe, 1'b0, 1'b1);
   endtask

endmodule

// File: doc/rs_encoder_param.md
RS_ENCODER_PARAM -- requirements
Module: rs_encoder_param

Interface
REQ-001 Parameter NPAR, default 8: parity symbols per codeword (2T); legal range 2..32.
REQ-002 Parameter MAX_K, default 247: maximum message symbols per codeword; legal range 1..(255-NPAR).
REQ-003 Parameter GEN, default 64'he3_2c_b2_47_ac_08_e0_25: packed generator coefficients, 8*NPAR bits; byte i (bits 8i+7:8i) = g_i; the monic x^NPAR term is implicit.
REQ-004 Parameter PRIM_POLY, default 9'h11d: GF(256) field polynomial x^8+x^4+x^3+x^2+1.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 din  input  8  message symbol.
REQ-008 din_val  input  1  din valid.
REQ-009 din_sop  input  1  first message symbol; qualified by din_val.
REQ-010 din_eop  input  1  last message symbol; qualified by din_val.
REQ-011 din_rdy  output  1  block accepts din this cycle.
REQ-012 dout  output  8  codeword symbol: message, then parity.
REQ-013 dout_val  output  1  dout valid.
REQ-014 dout_sop / dout_eop  output  1 each  first / last codeword symbol; qualified by dout_val.
REQ-015 dout_rdy  input  1  downstream accepts dout this cycle.
REQ-016 busy  output  1  codeword in progress or output pending.
REQ-017 err_len / err_proto  output  1 each  one-cycle error pulses.

Function
REQ-018 Beat accepted = din_val & din_rdy; output transfer = dout_val & dout_rdy.
REQ-019 States: IDLE, MSG, PAR.
REQ-020 din_rdy = (state != PAR) & (!dout_val | dout_rdy).
REQ-021 Systematic, registered output: each accepted beat appears on dout one cycle later with dout_val=1; dout_sop copies din_sop; dout_eop=0 for message symbols.
REQ-022 The output register holds dout, dout_val, dout_sop and dout_eop stable while dout_val & !dout_rdy.
REQ-023 Division, per accepted beat: fb = din ^ (sop ? 0 : rem[NPAR-1]).
REQ-024 rem[0] <= fb*g_0.
REQ-025 rem[i] <= (sop ? 0 : rem[i-1]) ^ fb*g_i for i > 0.
REQ-026 All products are GF(256) multiplications modulo PRIM_POLY.
REQ-027 IDLE: an accepted sop beat goes to MSG.
REQ-028 IDLE: an accepted sop & eop beat goes directly to PAR.
REQ-029 IDLE: an accepted beat without sop is discarded (no dout) and err_proto pulses.
REQ-030 MSG: an accepted eop beat goes to PAR.
REQ-031 Symbol counter counts accepted beats from sop; the MAX_K-th beat without eop is treated as eop (goes to PAR) and err_len pulses.
REQ-032 MSG: an accepted sop beat aborts the codeword, pulses err_proto, and restarts division with this beat as a new sop.
REQ-033 Abort output: the aborted codeword emits no parity; the new sop symbol is output normally with dout_sop=1.
REQ-034 PAR: emits rem[NPAR-1] down to rem[0], one symbol per cycle in which the output register is free or transferring.
REQ-035 PAR: the remainder shifts only on a parity load; the last parity symbol has dout_eop=1, then state returns to IDLE.
REQ-036 PAR: din_rdy=0; input beats are not accepted.
REQ-037 Minimum cycle: with dout_rdy held 1, L message symbols produce L+NPAR contiguous dout_val cycles, first output 1 cycle after first accept; next sop accepted the cycle after the last parity load.
REQ-038 busy = (state != IDLE) | dout_val.

Reset
REQ-039 While rst=1, at each rising edge: state IDLE, remainder and symbol counter 0, dout=0, dout_val=dout_sop=dout_eop=0, err_len=err_proto=0.
REQ-040 While rst=1, din_rdy=0; din_rdy=1 in the first cycle after rst falls.
REQ-041 Reset in MSG or PAR discards the codeword; no partial parity is emitted afterwards.

Verification
REQ-042 Defaults, single symbol 0x01 with sop & eop, dout_rdy=1 -> dout 01,e3,2c,b2,47,ac,08,e0,25; dout_sop on 01, dout_eop on 25.
REQ-043 247 symbols of 0x00 -> 255 outputs, all parity 0x00, dout_eop on output 255.
REQ-044 Same single-symbol 0x01 codeword, dout_rdy=0 for 3 cycles while 2c is presented -> 2c held stable; full sequence unchanged, no duplicates.
REQ-045 sop at beat 5 of a message -> err_proto pulse; no parity for the first codeword; second codeword parity matches a golden model.
REQ-046 248 beats, no eop -> err_len pulse at beat 247; 8 parity symbols follow; beat 248 is not accepted while in PAR; after parity, beat 248 is treated as a beat in IDLE (discarded, err_proto pulse if it lacks sop).
REQ-047 rst=1 during the third parity symbol -> next cycle dout_val=0; new codeword after reset gives golden parity.
